// File: rtl/wb_counter_bank.sv
// Wishbone-mapped bank of CHANNELS up/down counters with compare match, sticky status and IRQ.
// Channel 0 additionally accepts a bitwise override from the logic analyzer.
module wb_counter_bank #(
   parameter int CHANNELS = 4,
   parameter int BITS     = 16
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic                     wbs_cyc_i,
   input  logic                     wbs_stb_i,
   input  logic                     wbs_we_i,
   input  logic [3:0]               wbs_sel_i,
   input  logic [31:0]              wbs_adr_i,
   input  logic [31:0]              wbs_dat_i,
   output logic                     wbs_ack_o,
   output logic [31:0]              wbs_dat_o,
   input  logic [BITS-1:0]          la_write,
   input  logic [BITS-1:0]          la_input,
   output logic [CHANNELS*BITS-1:0] count_o,
   output logic [CHANNELS-1:0]      irq_o
);

   logic [BITS-1:0]     count_q   [CHANNELS];
   logic [BITS-1:0]     compare_q [CHANNELS];
   logic [3:0]          ctrl_q    [CHANNELS];
   logic [CHANNELS-1:0] match_q;

   logic [BITS-1:0]     count_d   [CHANNELS];
   logic [BITS-1:0]     compare_d [CHANNELS];
   logic [3:0]          ctrl_d    [CHANNELS];
   logic [CHANNELS-1:0] match_d;
   logic [CHANNELS-1:0] hit;

   logic            accept;
   logic            wr;
   logic            wr_ch;
   logic [2:0]      chan;
   logic [1:0]      regsel;
   logic [BITS-1:0] wmask;
   logic [BITS-1:0] nxt;
   logic [31:0]     rdata;
   logic            unused_bits;

   assign accept      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
   assign wr          = accept & wbs_we_i;
   assign chan        = wbs_adr_i[6:4];
   assign regsel      = wbs_adr_i[3:2];
   assign unused_bits = ^{wbs_adr_i[31:7], wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i};

   always_comb begin
      wmask = '0;
      for (int b = 0; b < BITS; b++) begin
         wmask[b] = wbs_sel_i[b/8];
      end
   end

   // Per channel: normal step, then LA override (ch0), then WB byte writes on top.
   always_comb begin
      rdata   = '0;
      match_d = match_q;
      hit     = '0;
      nxt     = '0;
      wr_ch   = 1'b0;
      for (int n = 0; n < CHANNELS; n++) begin
         wr_ch  = wr && (chan == 3'(n));
         hit[n] = ctrl_q[n][0] && (count_q[n] == compare_q[n]);

         if (!ctrl_q[n][0] || (hit[n] && ctrl_q[n][2]))
            nxt = count_q[n];
         else if (ctrl_q[n][1])
            nxt = count_q[n] - BITS'(1);
         else
            nxt = count_q[n] + BITS'(1);
         if (n == 0)
            nxt = (nxt & ~la_write) | (la_input & la_write);
         if (wr_ch && regsel == 2'd0)
            nxt = (nxt & ~wmask) | (wbs_dat_i[BITS-1:0] & wmask);
         count_d[n] = nxt;

         compare_d[n] = compare_q[n];
         if (wr_ch && regsel == 2'd1)
            compare_d[n] = (compare_q[n] & ~wmask) | (wbs_dat_i[BITS-1:0] & wmask);

         ctrl_d[n] = ctrl_q[n];
         if (hit[n] && ctrl_q[n][2])
            ctrl_d[n][0] = 1'b0;
         if (wr_ch && regsel == 2'd2 && wbs_sel_i[0])
            ctrl_d[n] = wbs_dat_i[3:0];

         if (wr_ch && regsel == 2'd3 && wbs_sel_i[0] && wbs_dat_i[0])
            match_d[n] = 1'b0;
         if (hit[n])
            match_d[n] = 1'b1;

         if (chan == 3'(n)) begin
            case (regsel)
               2'd0:    rdata = 32'(count_q[n]);
               2'd1:    rdata = 32'(compare_q[n]);
               2'd2:    rdata = {28'd0, ctrl_q[n]};
               default: rdata = {31'd0, match_q[n]};
            endcase
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int n = 0; n < CHANNELS; n++) begin
            count_q[n]   <= '0;
            compare_q[n] <= '1;
            ctrl_q[n]    <= '0;
         end
         match_q   <= '0;
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         for (int n = 0; n < CHANNELS; n++) begin
            count_q[n]   <= count_d[n];
            compare_q[n] <= compare_d[n];
            ctrl_q[n]    <= ctrl_d[n];
         end
         match_q   <= match_d;
         wbs_ack_o <= accept;
         if (accept)
            wbs_dat_o <= rdata;
      end
   end

   always_comb begin
      count_o = '0;
      irq_o   = '0;
      for (int n = 0; n < CHANNELS; n++) begin
         count_o[n*BITS +: BITS] = count_q[n];
         irq_o[n]                = match_q[n] & ctrl_q[n][3];
      end
   end

endmodule

// File: tb/tb_wb_counter_bank.sv
// Bench for wb_counter_bank: directed Wishbone traffic, an abstract per-channel model
// checked every cycle, plus hand-computed literal expectations.
module tb_wb_counter_bank;

   localparam int     CHANNELS = 4;
   localparam int     BITS     = 16;
   localparam longint MAXV     = (64'd1 << BITS) - 1;

   logic                     wb_clk_i = 1'b0;
   logic                     wb_rst_i = 1'b1;
   logic                     wbs_cyc_i = 1'b0;
   logic                     wbs_stb_i = 1'b0;
   logic                     wbs_we_i = 1'b0;
   logic [3:0]               wbs_sel_i = 4'h0;
   logic [31:0]              wbs_adr_i = '0;
   logic [31:0]              wbs_dat_i = '0;
   logic                     wbs_ack_o;
   logic [31:0]              wbs_dat_o;
   logic [BITS-1:0]          la_write = '0;
   logic [BITS-1:0]          la_input = '0;
   logic [CHANNELS*BITS-1:0] count_o;
   logic [CHANNELS-1:0]      irq_o;

   int checks = 0;
   int errors = 0;
   bit checking = 1'b0;

   longint m_count [CHANNELS];
   longint m_cmp   [CHANNELS];
   bit     m_en    [CHANNELS];
   bit     m_down  [CHANNELS];
   bit     m_os    [CHANNELS];
   bit     m_ien   [CHANNELS];
   bit     m_match [CHANNELS];
   bit     m_ack;
   longint m_dat;

   wb_counter_bank #(.CHANNELS(CHANNELS), .BITS(BITS)) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_stb_i (wbs_stb_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o),
      .la_write  (la_write),
      .la_input  (la_input),
      .count_o   (count_o),
      .irq_o     (irq_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint read_model(input int ch, input int r);
      if (ch >= CHANNELS) return 0;
      case (r)
         0:       return m_count[ch];
         1:       return m_cmp[ch];
         2:       return longint'({m_ien[ch], m_os[ch], m_down[ch], m_en[ch]});
         default: return longint'(m_match[ch]);
      endcase
   endfunction

   // Reference behaviour: one register-transfer step per clock, computed in plain integers.
   always @(posedge wb_clk_i) begin : model_proc
      bit     acc, hit;
      int     ch, r;
      longint nc, bm, wd, law, lai;
      if (wb_rst_i) begin
         for (int n = 0; n < CHANNELS; n++) begin
            m_count[n] = 0; m_cmp[n] = MAXV; m_match[n] = 0;
            m_en[n] = 0; m_down[n] = 0; m_os[n] = 0; m_ien[n] = 0;
         end
         m_ack = 0;
         m_dat = 0;
      end else begin
         acc = wbs_cyc_i && wbs_stb_i && !m_ack;
         ch  = int'(wbs_adr_i[6:4]);
         r   = int'(wbs_adr_i[3:2]);
         wd  = longint'(wbs_dat_i);
         law = longint'(la_write);
         lai = longint'(la_input);
         bm  = 0;
         for (int k = 0; k < 4; k++)
            if (wbs_sel_i[k]) bm = bm | (longint'(255) << (8 * k));
         bm = bm & MAXV;
         if (acc) m_dat = read_model(ch, r);
         m_ack = acc;
         for (int n = 0; n < CHANNELS; n++) begin
            hit = m_en[n] && (m_count[n] == m_cmp[n]);
            nc  = m_count[n];
            if (m_en[n] && !(hit && m_os[n]))
               nc = m_down[n] ? (nc + MAXV) % (MAXV + 1) : (nc + 1) % (MAXV + 1);
            if (n == 0) nc = (nc & ~law) | (lai & law);
            if (hit && m_os[n]) m_en[n] = 0;
            if (acc && wbs_we_i && ch == n) begin
               case (r)
                  0: nc = (nc & ~bm) | (wd & bm);
                  1: m_cmp[n] = (m_cmp[n] & ~bm) | (wd & bm);
                  2: if (wbs_sel_i[0]) begin
                        m_en[n] = wd[0]; m_down[n] = wd[1]; m_os[n] = wd[2]; m_ien[n] = wd[3];
                     end
                  default: if (wbs_sel_i[0] && wd[0]) m_match[n] = 0;
               endcase
            end
            if (hit) m_match[n] = 1;
            m_count[n] = nc;
         end
      end
   end

   always @(negedge wb_clk_i) begin : compare_proc
      logic [CHANNELS-1:0] irq_exp;
      if (checking) begin
         irq_exp = '0;
         for (int n = 0; n < CHANNELS; n++) begin
            irq_exp[n] = m_match[n] & m_ien[n];
            check_output($sformatf("count%0d", n), 32'(count_o[n*BITS +: BITS]), 32'(m_count[n]));
         end
         check_output("irq", 32'(irq_o), 32'(irq_exp));
         check_output("ack", 32'(wbs_ack_o), 32'(m_ack));
         if (m_ack) check_output("rdata", wbs_dat_o, 32'(m_dat));
      end
   end

   // One bounded Wishbone transaction; returns just after the ack edge.
   task automatic apply_stimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, output logic [31:0] rd);
      int waited = 0;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
      do begin
         @(posedge wb_clk_i); #1;
         waited++;
      end while (!wbs_ack_o && waited < 8);
      check_output("ack_wait", 32'(wbs_ack_o), 32'd1);
      rd = wbs_dat_o;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
   endtask

   task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      logic [31:0] rd;
      apply_stimulus(1'b1, adr, dat, sel, rd);
   endtask

   task automatic wb_read_expect(input string name, input logic [31:0] adr, input logic [31:0] exp);
      logic [31:0] rd;
      apply_stimulus(1'b0, adr, 32'd0, 4'hF, rd);
      check_output(name, rd, exp);
   endtask

   task automatic step_cycles(input int n);
      repeat (n) @(posedge wb_clk_i);
      #1;
   endtask

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      logic [15:0] ch2_seq [5];
      ch2_seq[0] = 16'h0002; ch2_seq[1] = 16'h0001; ch2_seq[2] = 16'h0000;
      ch2_seq[3] = 16'hFFFF; ch2_seq[4] = 16'hFFFE;

      step_cycles(3);
      wb_rst_i = 1'b0;
      checking = 1'b1;

      $display("[TB] reset values of channel 0");
      wb_read_expect("ch0_count_rst",   32'h00, 32'h0000_0000);
      wb_read_expect("ch0_compare_rst", 32'h04, 32'h0000_FFFF);
      wb_read_expect("ch0_ctrl_rst",    32'h08, 32'h0000_0000);
      wb_read_expect("ch0_status_rst",  32'h0C, 32'h0000_0000);

      $display("[TB] channel 1 oneshot");
      wb_write(32'h14, 32'd5, 4'hF);
      wb_write(32'h18, 32'hD, 4'hF);
      step_cycles(8);
      check_output("ch1_hold", 32'(count_o[31:16]), 32'd5);
      check_output("ch1_irq", 32'(irq_o[1]), 32'd1);
      wb_read_expect("ch1_ctrl_cleared", 32'h18, 32'hC);
      wb_read_expect("ch1_status", 32'h1C, 32'h1);
      wb_write(32'h1C, 32'h1, 4'h1);
      check_output("ch1_irq_w1c", 32'(irq_o[1]), 32'd0);

      $display("[TB] channel 2 down count through wrap");
      wb_write(32'h20, 32'h2, 4'hF);
      wb_write(32'h28, 32'h3, 4'hF);
      for (int i = 0; i < 5; i++) begin
         check_output($sformatf("ch2_seq%0d", i), 32'(count_o[47:32]), 32'(ch2_seq[i]));
         step_cycles(1);
      end
      wb_read_expect("ch2_status_wrap", 32'h2C, 32'h1);
      wb_write(32'h28, 32'h0, 4'hF);

      $display("[TB] channel 0 logic-analyzer override");
      la_write = 16'h00FF;
      la_input = 16'h0012;
      wb_write(32'h08, 32'h1, 4'hF);
      step_cycles(3);
      check_output("ch0_la_pin", 32'(count_o[15:0]), 32'h0012);
      wb_write(32'h00, 32'h34, 4'h1);
      check_output("ch0_wb_over_la", 32'(count_o[15:0]), 32'h0034);
      step_cycles(1);
      check_output("ch0_la_repin", 32'(count_o[15:0]), 32'h0012);
      la_write = '0;
      wb_write(32'h08, 32'h0, 4'hF);

      $display("[TB] channel 3 set beats W1C");
      wb_write(32'h34, 32'd8, 4'hF);
      wb_write(32'h38, 32'h9, 4'hF);
      step_cycles(8);
      wb_write(32'h3C, 32'h1, 4'h1);
      wb_read_expect("ch3_status_set_wins", 32'h3C, 32'h1);
      check_output("ch3_irq", 32'(irq_o[3]), 32'd1);

      $display("[TB] out-of-range channel");
      wb_read_expect("ch7_count", 32'h70, 32'h0);
      wb_read_expect("ch7_ctrl",  32'h78, 32'h0);
      wb_write(32'h70, 32'hFFFF, 4'hF);
      wb_write(32'h74, 32'h0, 4'hF);
      wb_write(32'h78, 32'hF, 4'hF);
      wb_read_expect("ch1_count_kept",   32'h10, 32'd5);
      wb_read_expect("ch1_compare_kept", 32'h14, 32'd5);

      $display("[TB] reset during a pending request");
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
      wbs_adr_i = 32'h04; wbs_sel_i = 4'hF;
      wb_rst_i = 1'b1;
      step_cycles(1);
      check_output("rst_ack_low0", 32'(wbs_ack_o), 32'd0);
      step_cycles(1);
      check_output("rst_ack_low1", 32'(wbs_ack_o), 32'd0);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      wb_rst_i = 1'b0;
      step_cycles(1);
      check_output("rst_irq_clear", 32'(irq_o), 32'd0);
      wb_read_expect("ch1_compare_after_rst", 32'h14, 32'h0000_FFFF);

      step_cycles(2);
      checking = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
